sub_bytes_folded: RTL and testbench

- Parametrised, folded successor to the 16-instance SubBytes stage for the modified AES-128 datapath.
- Accepts one 128-bit state and one 128-bit round key through a valid/ready handshake.
- Applies the column key-mix pre-XOR (configurable) and substitutes LANES bytes per cycle through LANES shared forward S-boxes.
- Presents the 128-bit result on a held output handshake; sits between AddRoundKey and ShiftRows and trades area for latency.

---
 rtl/sub_bytes_folded.sv | 146 ++++++++++++++
 tb/tb_sub_bytes_folded.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_folded.sv
// sub_bytes_folded: folded AES SubBytes, LANES shared forward S-boxes over 16/LANES beats.
// Define MOD_KEY_MIX_EN to apply the column key-mix pre-XOR to the state at capture.
module sub_bytes_folded #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         IN_VALID,
   output logic         IN_READY,
   input  logic [127:0] IN_DATA,
   input  logic [127:0] IN_KEY,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic [127:0] SB_DATA,
   output logic         BUSY
);
   localparam int BEATS = 16 / LANES;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
      $error("sub_bytes_folded: LANES must be 1, 2, 4, 8 or 16");
   end

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[x];
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   k_q, k_d;
   logic [127:0]    work_q, work_d;
   logic [127:0]    sb_q, sb_d;
   logic            out_valid_q, out_valid_d;
   logic            busy_q, busy_d;
   logic [127:0]    mixed;
   logic [7:0]      lane_in  [LANES];
   logic [7:0]      lane_out [LANES];
   logic            accept;

`ifdef MOD_KEY_MIX_EN
   logic [7:0] kx [4];
   always_comb begin
      mixed = '0;
      for (int c = 0; c < 4; c++)
         kx[c] = IN_KEY[127-8*c -: 8] ^ IN_KEY[95-8*c -: 8] ^ IN_KEY[63-8*c -: 8] ^ IN_KEY[31-8*c -: 8];
      for (int i = 0; i < 16; i++)
         mixed[127-8*i -: 8] = IN_DATA[127-8*i -: 8] ^ kx[i % 4];
   end
`else
   logic unused_key;
   assign unused_key = ^IN_KEY;
   assign mixed      = IN_DATA;
`endif

   // Handshakes: a transfer happens on an edge where valid && ready are both high. IN side accepts
   // only in IDLE; OUT_VALID stays high with SB_DATA frozen until OUT_READY is seen in DONE.
   assign IN_READY = (state_q == S_IDLE) && !rst;
   assign accept   = IN_VALID && IN_READY;

   // Beat k feeds bytes k*LANES .. k*LANES+LANES-1 of the work register into the shared lanes.
   always_comb begin
      for (int l = 0; l < LANES; l++) lane_in[l] = '0;
      for (int b = 0; b < 16; b++)
         if (b / LANES == int'(k_q)) lane_in[b % LANES] = work_q[127-8*b -: 8];
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_out[l] = sbox(lane_in[l]);
   end

   always_comb begin
      sb_d = sb_q;
      if (state_q == S_RUN)
         for (int b = 0; b < 16; b++)
            if (b / LANES == int'(k_q)) sb_d[127-8*b -: 8] = lane_out[b % LANES];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_RUN;
         S_RUN:   if (int'(k_q) == BEATS - 1) state_d = S_DONE;
         S_DONE:  if (OUT_READY) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      work_d      = work_q;
      k_d         = k_q;
      if (accept) begin
         work_d = mixed;
         k_d    = '0;
      end else if (state_q == S_RUN) begin
         k_d = k_q + CW'(1);
      end
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d == S_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q         <= '0;
         work_q      <= '0;
         sb_q        <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         k_q         <= k_d;
         work_q      <= work_d;
         sb_q        <= sb_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign SB_DATA   = sb_q;
   assign OUT_VALID = out_valid_q;
   assign BUSY      = busy_q;

endmodule

// File: tb/tb_sub_bytes_folded.sv
// Bench for sub_bytes_folded: five instances (LANES 1,2,4,8,16) against a GF(2^8)-derived S-box model.
// Honours MOD_KEY_MIX_EN in its reference model the same way the design does.
`timescale 1ns/1ps
module tb_sub_bytes_folded;
   localparam int N = 5;
   localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [127:0]  in_data, in_key;
   logic          in_valid  [N];
   logic          out_ready [N];
   logic          in_ready  [N];
   logic          out_valid [N];
   logic          busy      [N];
   logic [127:0]  sb_data   [N];

   int            tests_run    = 0;
   int            tests_failed = 0;
   logic [7:0]    sbox_ref [256];
   logic [127:0]  exp_q [$];

   for (genvar g = 0; g < N; g++) begin : g_dut
      sub_bytes_folded #(.LANES(1 << g)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .IN_VALID  (in_valid[g]),
         .IN_READY  (in_ready[g]),
         .IN_DATA   (in_data),
         .IN_KEY    (in_key),
         .OUT_VALID (out_valid[g]),
         .OUT_READY (out_ready[g]),
         .SB_DATA   (sb_data[g]),
         .BUSY      (busy[g])
      );
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference S-box: multiplicative inverse in GF(2^8) followed by the FIPS-197 affine map.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic       hi;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         hi = a[7];
         a  = a << 1;
         if (hi) a ^= 8'h1b;
         b  = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k);
      logic [7:0]   col [4];
      logic [127:0] r;
      for (int c = 0; c < 4; c++) begin
         col[c] = 8'h00;
`ifdef MOD_KEY_MIX_EN
         for (int w = 0; w < 4; w++) col[c] ^= k[127-8*(4*w+c) -: 8];
`endif
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_ref[d[127-8*i -: 8] ^ col[i % 4]];
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // One accept-to-release transaction on instance u. Latency counts rising edges from the accept
   // edge (inclusive) up to the edge after which OUT_VALID is first seen high.
   task automatic transact(input int u, input logic [127:0] d, input logic [127:0] k,
                           input bit early_ready, input int hold, input bit pulse);
      int           edges;
      logic [127:0] exp, held;
      @(negedge clk);
      check($sformatf("in_ready_idle_u%0d", u), 128'(in_ready[u]), 128'd1);
      in_valid[u] = 1'b1;
      in_data     = d;
      in_key      = k;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      in_valid[u] = 1'b0;
      in_data     = rand128();
      in_key      = rand128();
      check($sformatf("busy_after_accept_u%0d", u), 128'(busy[u]), 128'd1);
      check($sformatf("in_ready_run_u%0d", u), 128'(in_ready[u]), 128'd0);
      if (early_ready) out_ready[u] = 1'b1;
      while (!out_valid[u] && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      out_ready[u] = 1'b0;
      check($sformatf("latency_u%0d", u), 128'(edges), 128'((16 >> u) + 1));
      exp = exp_q.pop_front();
      check($sformatf("sb_data_u%0d", u), sb_data[u], exp);
      check($sformatf("busy_done_u%0d", u), 128'(busy[u]), 128'd0);
      held = sb_data[u];
      for (int h = 0; h < hold; h++) begin
         if (pulse) begin
            in_valid[u] = 1'b1;
            in_data     = rand128();
         end
         @(posedge clk);
         @(negedge clk);
         check($sformatf("hold_valid_u%0d", u), 128'(out_valid[u]), 128'd1);
         check($sformatf("hold_data_u%0d", u), sb_data[u], held);
         check($sformatf("hold_in_ready_u%0d", u), 128'(in_ready[u]), 128'd0);
      end
      in_valid[u]  = 1'b0;
      out_ready[u] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready[u] = 1'b0;
      check($sformatf("released_valid_u%0d", u), 128'(out_valid[u]), 128'd0);
      check($sformatf("released_busy_u%0d", u), 128'(busy[u]), 128'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog timeout tests=%0d", tests_run);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] d, k;
      int           u;
      bit           any_valid;

      build_sbox();
      rst     = 1'b1;
      in_data = '0;
      in_key  = '0;
      for (int i = 0; i < N; i++) begin
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < N; i++) begin
         check($sformatf("rst_in_ready_u%0d", i), 128'(in_ready[i]), 128'd0);
         check($sformatf("rst_out_valid_u%0d", i), 128'(out_valid[i]), 128'd0);
         check($sformatf("rst_busy_u%0d", i), 128'(busy[i]), 128'd0);
         check($sformatf("rst_sb_data_u%0d", i), sb_data[i], 128'd0);
      end
      rst = 1'b0;
      #1;
      for (int i = 0; i < N; i++)
         check($sformatf("post_rst_in_ready_u%0d", i), 128'(in_ready[i]), 128'd1);

      // FIPS-197 SubBytes vector across every lane count.
      for (int i = 0; i < N; i++) begin
         exp_q.push_back(FIPS_OUT);
         transact(i, FIPS_IN, '0, 1'b0, 0, 1'b0);
      end

      // Key-mix and key cancellation on the default LANES=4 instance.
`ifdef MOD_KEY_MIX_EN
      exp_q.push_back({4{32'h7c636363}});
`else
      exp_q.push_back({16{8'h63}});
`endif
      transact(2, '0, 128'h01000000_00000000_00000000_00000000, 1'b0, 0, 1'b0);
      exp_q.push_back({16{8'h63}});
      transact(2, '0, 128'hab000000_ab000000_00000000_00000000, 1'b0, 0, 1'b0);

      // Backpressure with ignored IN_VALID pulses, then a normal follow-up accept.
      d = rand128();
      k = rand128();
      exp_q.push_back(model(d, k));
      transact(2, d, k, 1'b0, 10, 1'b1);
      d = rand128();
      k = rand128();
      exp_q.push_back(model(d, k));
      transact(2, d, k, 1'b0, 0, 1'b0);

      // Randomized traffic across instances, with early OUT_READY and short holds.
      repeat (20) begin
         u = $urandom_range(0, N - 1);
         d = rand128();
         k = rand128();
         exp_q.push_back(model(d, k));
         transact(u, d, k, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a LANES=1 run.
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_data     = FIPS_IN;
      in_key      = '0;
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrun_rst_out_valid", 128'(out_valid[0]), 128'd0);
      check("midrun_rst_sb_data", sb_data[0], 128'd0);
      check("midrun_rst_busy", 128'(busy[0]), 128'd0);
      check("midrun_rst_in_ready", 128'(in_ready[0]), 128'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrun_post_rst_in_ready", 128'(in_ready[0]), 128'd1);
      any_valid = 1'b0;
      repeat (25) begin
         @(negedge clk);
         any_valid |= out_valid[0] | busy[0];
      end
      check("midrun_no_stale_result", 128'(any_valid), 128'd0);
      exp_q.push_back(FIPS_OUT);
      transact(0, FIPS_IN, '0, 1'b0, 0, 1'b0);

      check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
